// File: rtl/alu_pkg.sv
// Shared definitions for the base ALU and the funct7=0x20 extra path (SUB/SRA).
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] FUNCT3_SUB = 3'h0;
  localparam logic [2:0] FUNCT3_SRA = 3'h5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sra_step.sv
// Combinational arithmetic right shift by 0..SHIFT_STEP bits, sign-filled.
// Setting SHIFT_STEP = XLEN turns it into a full single-cycle barrel SRA.
module sra_step
  import alu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int SHIFT_STEP = 4,
  localparam int AMT_W     = $clog2(SHIFT_STEP + 1)
) (
  input  logic [XLEN-1:0]  data,
  input  logic [AMT_W-1:0] amount,
  output logic [XLEN-1:0]  result
);

  assign result = $signed(data) >>> amount;

endmodule

// File: rtl/alu_extra_seq.sv
// SUB / SRA execution unit with valid/ready on both sides; SUB and SRA-by-0 finish at the accept edge,
// SRA takes ceil(shamt/SHIFT_STEP) further edges; the result is held in DONE until out_ready.
module alu_extra_seq
  import alu_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int SHIFT_STEP = 4,
  localparam int SHAMT_W   = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] register_data_1,
  input  logic [XLEN-1:0] register_data_2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] register_data_out,
  output logic            illegal_op
);

  localparam int AMT_W = $clog2(SHIFT_STEP + 1);

  state_t            state, state_nxt;
  logic [XLEN-1:0]    acc, acc_nxt;
  logic [XLEN-1:0]    res, res_nxt;
  logic [XLEN-1:0]    acc_shifted;
  logic [SHAMT_W-1:0] rem, rem_nxt, rem_left;
  logic [SHAMT_W-1:0] shamt;
  logic [AMT_W-1:0]   step;
  logic               ill, ill_nxt;
  logic               unused_rs2_hi;

  // Only the low SHAMT_W bits of rs2 carry a shift amount.
  assign shamt         = register_data_2[SHAMT_W-1:0];
  assign unused_rs2_hi = ^register_data_2[XLEN-1:SHAMT_W];

  always_comb begin
    step = AMT_W'(rem);
    if (32'(rem) > 32'(SHIFT_STEP)) begin
      step = AMT_W'(SHIFT_STEP);
    end
  end

  assign rem_left = rem - SHAMT_W'(step);

  sra_step #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_sra_step (
    .data   (acc),
    .amount (step),
    .result (acc_shifted)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    res_nxt   = res;
    ill_nxt   = ill;
    if (flush) begin
      state_nxt = IDLE;
      ill_nxt   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_nxt = DONE;
            ill_nxt   = 1'b0;
            case (funct3)
              FUNCT3_SUB: res_nxt = register_data_1 - register_data_2;
              FUNCT3_SRA: begin
                if (shamt == '0) begin
                  res_nxt = register_data_1;
                end else begin
                  acc_nxt   = register_data_1;
                  rem_nxt   = shamt;
                  state_nxt = SHIFT;
                end
              end
              default: begin
                res_nxt = '0;
                ill_nxt = 1'b1;
              end
            endcase
          end
        end
        SHIFT: begin
          acc_nxt = acc_shifted;
          rem_nxt = rem_left;
          if (rem_left == '0) begin
            res_nxt   = acc_shifted;
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt = IDLE;
            ill_nxt   = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      rem   <= '0;
      res   <= '0;
      ill   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      rem   <= rem_nxt;
      res   <= res_nxt;
      ill   <= ill_nxt;
    end
  end

  assign in_ready          = (state == IDLE);
  assign out_valid         = (state == DONE);
  assign register_data_out = res;
  assign illegal_op        = ill;

  // A stalled result must not move until the consumer takes it.
  a_hold_result : assert property (
    @(posedge clock) disable iff (!reset_n)
      (out_valid && !out_ready && !flush) |=> (out_valid && $stable(register_data_out) && $stable(illegal_op))
  );

  a_shift_nonzero : assert property (
    @(posedge clock) disable iff (!reset_n)
      (state == SHIFT) |-> (rem != '0)
  );

endmodule
